// File: rtl/tea_decrypt_if.sv
// Ciphertext-in / plaintext-out bundle of the TEA decryptor.
// Latency: none (wiring only).
// Backpressure: in_valid/in_ready on the input side, out_valid/out_ready on the output side.
// Signals: key[127:0], in_data[63:0], in_valid, in_ready, out_data[63:0], out_valid, out_ready, busy.
// master = producer/consumer around the block, slave = the decryptor itself.
interface tea_decrypt_if;
  logic [127:0] key;
  logic [63:0]  in_data;
  logic         in_valid;
  logic         in_ready;
  logic [63:0]  out_data;
  logic         out_valid;
  logic         out_ready;
  logic         busy;

  modport master (
    output key, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, busy
  );

  modport slave (
    input  key, in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, busy
  );
endinterface

// File: rtl/tea_decrypt_ctrl.sv
// TEA block decryptor, one half-round per clock (v1 update, then v0 update).
// Latency: 2*ROUNDS edges from the accept edge to the edge that raises out_valid.
// Backpressure: in_ready only in IDLE; the plaintext is held in DONE until out_ready.
// Ports: clk, rst_n (synchronous, active-low), bus (tea_decrypt_if.slave),
//        abort (only when TEA_DEC_ABORT_EN is defined: drops an in-flight block).
// Optional feature macro: TEA_DEC_ABORT_EN.
module tea_decrypt_ctrl #(
  parameter int          ROUNDS = 32,
  parameter logic [31:0] DELTA  = 32'h9E3779B9
) (
  input  logic         clk,
  input  logic         rst_n,
`ifdef TEA_DEC_ABORT_EN
  input  logic         abort,
`endif
  tea_decrypt_if.slave bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] HALF_A = 2'd1;
  localparam logic [1:0] HALF_B = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  // Decryption starts from the sum left after ROUNDS encryption steps.
  localparam logic [63:0] SUM_PROD = 64'(DELTA) * 64'(ROUNDS);
  localparam logic [31:0] SUM_INIT = SUM_PROD[31:0];
  localparam logic [5:0]  LAST_RND = 6'(ROUNDS - 1);

  function automatic logic [31:0] tea_f(input logic [31:0] x,
                                        input logic [31:0] kl,
                                        input logic [31:0] kr,
                                        input logic [31:0] s);
    return ((x << 4) + kl) ^ (x + s) ^ ((x >> 5) + kr);
  endfunction

  logic [1:0]   state;
  logic [127:0] k;
  logic [31:0]  v0;
  logic [31:0]  v1;
  logic [31:0]  sum;
  logic [5:0]   rnd;
  logic [63:0]  out_q;
  logic         abort_hit;

  logic [31:0]  v1_next;
  logic [31:0]  v0_next;

  // HALF_B uses the v1 already written back by the preceding HALF_A edge.
  assign v1_next = v1 - tea_f(v0, k[95:64], k[127:96], sum);
  assign v0_next = v0 - tea_f(v1, k[31:0],  k[63:32],  sum);

`ifdef TEA_DEC_ABORT_EN
  assign abort_hit = abort && (state != IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      k     <= '0;
      v0    <= '0;
      v1    <= '0;
      sum   <= '0;
      rnd   <= '0;
      out_q <= '0;
    end else if (abort_hit) begin
      // Working registers are simply reloaded on the next accept;
      // out_q keeps the last completed plaintext.
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            k     <= bus.key;
            v0    <= bus.in_data[31:0];
            v1    <= bus.in_data[63:32];
            sum   <= SUM_INIT;
            rnd   <= '0;
            state <= HALF_A;
          end
        end
        HALF_A: begin
          v1    <= v1_next;
          state <= HALF_B;
        end
        HALF_B: begin
          v0  <= v0_next;
          sum <= sum - DELTA;
          rnd <= rnd + 6'd1;
          if (rnd == LAST_RND) begin
            // Capture the result separately so the output only changes on completion.
            out_q <= {v1, v0_next};
            state <= DONE;
          end else begin
            state <= HALF_A;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state == HALF_A) || (state == HALF_B);
  assign bus.out_data  = out_q;

endmodule

// File: tb/tb_tea_decrypt_ctrl.sv
module tb_tea_decrypt_ctrl;

  localparam int          ROUNDS = 32;
  localparam logic [31:0] DELTA  = 32'h9E3779B9;
  localparam int          LAT    = 2 * ROUNDS;

  logic clk;
  logic rst_n;
  logic abort;

  tea_decrypt_if bus ();

  tea_decrypt_ctrl #(.ROUNDS(ROUNDS), .DELTA(DELTA)) dut (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef TEA_DEC_ABORT_EN
    .abort (abort),
`endif
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference: forward TEA encryption written straight from the cipher definition.
  // The decryptor is checked by feeding it enc(pt) and expecting pt back.
  function automatic logic [63:0] tea_enc(input logic [127:0] kk, input logic [63:0] p);
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] s;
    a = p[31:0];
    b = p[63:32];
    s = 32'd0;
    for (int i = 0; i < ROUNDS; i++) begin
      s = s + DELTA;
      a = a + (((b << 4) + kk[31:0])  ^ (b + s) ^ ((b >> 5) + kk[63:32]));
      b = b + (((a << 4) + kk[95:64]) ^ (a + s) ^ ((a >> 5) + kk[127:96]));
    end
    return {b, a};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [63:0] rand_blk();
    return {$urandom, $urandom};
  endfunction

  // Presents a block and returns at the negedge following the accept edge.
  task automatic accept_block(input string tag, input logic [127:0] kk, input logic [63:0] ct);
    int t;
    @(negedge clk);
    bus.key      = kk;
    bus.in_data  = ct;
    bus.in_valid = 1'b1;
    t = 0;
    while (!bus.in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check({tag, "_busy_after_accept"}, 64'(bus.busy), 64'd1);
  endtask

  // Counts edges after the accept edge until out_valid is seen.
  task automatic wait_out(input int start, output int lat);
    lat = start;
    while (!bus.out_valid && lat < 300) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic finish_out(input string tag, input logic [63:0] exp, input int hold);
    check({tag, "_out_data"}, bus.out_data, exp);
    bus.out_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, 64'(bus.out_valid), 64'd1);
      check({tag, "_hold_data"},  bus.out_data, exp);
      check({tag, "_hold_ready"}, 64'(bus.in_ready), 64'd0);
      check({tag, "_hold_busy"},  64'(bus.busy), 64'd0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, "_idle_valid"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_idle_ready"}, 64'(bus.in_ready), 64'd1);
    check({tag, "_idle_keep"},  bus.out_data, exp);
  endtask

  task automatic run_block(input string tag, input logic [127:0] kk, input logic [63:0] pt, input int hold);
    int lat;
    accept_block(tag, kk, tea_enc(kk, pt));
    wait_out(0, lat);
    check({tag, "_latency"}, 64'(lat), 64'(LAT));
    finish_out(tag, pt, hold);
  endtask

  task automatic watch_no_valid(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    check({tag, "_no_out_valid"}, 64'(seen), 64'd0);
  endtask

  initial begin : stim
    logic [127:0] k1;
    logic [127:0] k2;
    logic [63:0]  p1;
    logic [63:0]  p2;
    logic [63:0]  vec_ct;
    int           lat;

    vec_ct = {32'h94BAA940, 32'h41EA3A0A};

    // Reset with in_valid already high: nothing may be accepted.
    rst_n        = 1'b0;
    abort        = 1'b0;
    bus.key      = '0;
    bus.in_data  = 64'h1234_5678_9ABC_DEF0;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy",      64'(bus.busy),      64'd0);
    check("rst_in_ready",  64'(bus.in_ready),  64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_data",  bus.out_data,       64'd0);
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_busy", 64'(bus.busy), 64'd0);

    // Known vector, out_ready effectively immediate.
    run_block("vec", 128'd0, 64'd0, 0);

    // Same vector with downstream stalled for 10 cycles.
    run_block("stall", 128'd0, 64'd0, 10);

    // Key/data changes with in_valid high while busy must be ignored.
    accept_block("ign", 128'd0, vec_ct);
    for (int i = 0; i < 15; i++) begin
      bus.in_valid = (i >= 5);
      bus.key      = rand_key();
      bus.in_data  = rand_blk();
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    wait_out(15, lat);
    check("ign_latency", 64'(lat), 64'(LAT));
    finish_out("ign", 64'd0, 2);

    // Random blocks with random downstream stalls.
    for (int n = 0; n < 4; n++) begin
      run_block("rnd", rand_key(), rand_blk(), $urandom_range(0, 3));
    end

    // Back-to-back with in_valid held high.
    k1 = rand_key();  p1 = rand_blk();
    k2 = rand_key();  p2 = rand_blk();
    @(negedge clk);
    bus.key = k1; bus.in_data = tea_enc(k1, p1); bus.in_valid = 1'b1;
    @(negedge clk);
    bus.key = k2; bus.in_data = tea_enc(k2, p2);
    check("b2b_first_busy", 64'(bus.busy), 64'd1);
    wait_out(0, lat);
    check("b2b_first_latency", 64'(lat), 64'(LAT));
    check("b2b_first_data", bus.out_data, p1);
    check("b2b_no_early_accept", 64'(bus.in_ready), 64'd0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("b2b_ready_after_hs", 64'(bus.in_ready), 64'd1);
    check("b2b_busy_after_hs",  64'(bus.busy),     64'd0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("b2b_second_busy", 64'(bus.busy), 64'd1);
    wait_out(0, lat);
    check("b2b_second_latency", 64'(lat), 64'(LAT));
    finish_out("b2b_second", p2, 1);

    // Reset pulse on the HALF_B edge of the 17th round.
    accept_block("mid_rst", rand_key(), rand_blk());
    repeat (33) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("mid_rst_out_data",  bus.out_data,       64'd0);
    check("mid_rst_in_ready",  64'(bus.in_ready),  64'd1);
    check("mid_rst_busy",      64'(bus.busy),      64'd0);
    watch_no_valid("mid_rst", 70);
    run_block("post_rst", rand_key(), rand_blk(), 1);

`ifdef TEA_DEC_ABORT_EN
    // Abort at edge 30 after accept.
    p1 = bus.out_data;
    accept_block("abort", rand_key(), rand_blk());
    repeat (29) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_in_ready",  64'(bus.in_ready),  64'd1);
    check("abort_busy",      64'(bus.busy),      64'd0);
    check("abort_out_valid", 64'(bus.out_valid), 64'd0);
    check("abort_out_data",  bus.out_data,       p1);
    watch_no_valid("abort", 70);
    run_block("post_abort", rand_key(), rand_blk(), 0);
`else
    // Without the abort port a started block always completes.
    run_block("no_abort", rand_key(), rand_blk(), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
